// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequence checker: FSM state encoding,
// run-counter width and the legal range of the lock threshold.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_e;

  // Width of the consecutive-match run counter.
  localparam int unsigned RUN_W = 4;

  // Legal range for LOCK_COUNT; the upper bound is what RUN_W can hold.
  localparam int unsigned LOCK_COUNT_MIN = 2;
  localparam int unsigned LOCK_COUNT_MAX = 15;

  function automatic bit lock_count_legal(input int unsigned n);
    return (n >= LOCK_COUNT_MIN) && (n <= LOCK_COUNT_MAX);
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating incrementer: adds one when requested, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  output logic [W-1:0] o_val
);

  assign o_val = (i_inc && (i_val != '1)) ? i_val + W'(1) : i_val;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running up-counter bus and checks that every valid sample
// is the previous one plus one (mod 2^WIDTH). Locks after LOCK_COUNT
// consecutive in-sequence samples, then pulses and counts each break.
//
// Build option: define COUNT_SEQ_RELOCK_EN to let the FAULT state re-seed
// and re-acquire lock; when undefined, FAULT is terminal until reset.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] last_bad
);

  if (!lock_count_legal(LOCK_COUNT)) begin : g_bad_lock_count
    $error("count_seq_checker: LOCK_COUNT out of range");
  end

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

  state_e           r_state;
  logic [RUN_W-1:0] r_run;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] r_last_bad;
  logic [ERR_W-1:0] r_err_count;
  logic             r_err_pulse;
  logic             r_locked;

  state_e           w_state_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [WIDTH-1:0] w_expected_nxt;
  logic [WIDTH-1:0] w_last_bad_nxt;
  logic [ERR_W-1:0] w_err_count_nxt;
  logic             w_err_pulse_nxt;
  logic             w_err_inc;
  logic             w_match;
  logic [WIDTH-1:0] w_din_inc;
  logic [RUN_W-1:0] w_run_inc;

  // Sample plus one wraps naturally at WIDTH bits, so all-ones -> 0 is in sequence.
  assign w_din_inc = din + WIDTH'(1);
  assign w_run_inc = r_run + RUN_W'(1);
  assign w_match   = (din == r_expected);

  // Error counter holds at all-ones once saturated.
  sat_counter #(
    .W (ERR_W)
  ) u_err_sat (
    .i_val (r_err_count),
    .i_inc (w_err_inc),
    .o_val (w_err_count_nxt)
  );

  // Next-state and next-output decode for one valid sample.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_run_nxt       = r_run;
    w_expected_nxt  = r_expected;
    w_last_bad_nxt  = r_last_bad;
    w_err_pulse_nxt = 1'b0;
    w_err_inc       = 1'b0;

    if (din_valid) begin
      unique case (r_state)
        IDLE: begin
          w_expected_nxt = w_din_inc;
          w_run_nxt      = RUN_W'(1);
          w_state_nxt    = ACQUIRE;
        end
        ACQUIRE: begin
          w_expected_nxt = w_din_inc;
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == LOCK_RUN) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            // Re-seed from the offending sample; no error while acquiring.
            w_run_nxt = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_expected_nxt = w_din_inc;
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_err_inc       = 1'b1;
            w_last_bad_nxt  = din;
            w_state_nxt     = FAULT;
          end
        end
        FAULT: begin
`ifdef COUNT_SEQ_RELOCK_EN
          // Behave like IDLE so the checker can re-acquire lock.
          w_expected_nxt = w_din_inc;
          w_run_nxt      = RUN_W'(1);
          w_state_nxt    = ACQUIRE;
`else
          // Terminal: everything holds until reset.
          w_state_nxt = FAULT;
`endif
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_expected  <= '0;
      r_last_bad  <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_expected  <= w_expected_nxt;
      r_last_bad  <= w_last_bad_nxt;
      r_err_count <= w_err_count_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;
  assign last_bad  = r_last_bad;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: table of sample/expected-output
// records plus hand-written sequences for acquire, async reset and
// (with COUNT_SEQ_RELOCK_EN) error-counter saturation.
module tb_count_seq_checker;

  localparam int WIDTH      = 4;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] last_bad;

  logic [7:0] sat_in;
  logic       sat_inc;
  logic [7:0] sat_out;

  int n_checks = 0;
  int n_pass   = 0;

  count_seq_checker #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected),
    .last_bad  (last_bad)
  );

  sat_counter #(.W(8)) u_sat (
    .i_val (sat_in),
    .i_inc (sat_inc),
    .o_val (sat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] din;
    logic             lk;
    logic             pl;
    logic [ERR_W-1:0] cnt;
    logic [WIDTH-1:0] ex;
    logic [WIDTH-1:0] lb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic lk, input logic pl,
                            input logic [ERR_W-1:0] cnt, input logic [WIDTH-1:0] ex,
                            input logic [WIDTH-1:0] lb);
    check({tag, ".locked"},    locked,    lk);
    check({tag, ".err_pulse"}, err_pulse, pl);
    check({tag, ".err_count"}, err_count, cnt);
    check({tag, ".expected"},  expected,  ex);
    check({tag, ".last_bad"},  last_bad,  lb);
  endtask

  task automatic add(input logic v, input int d, input logic lk, input logic pl,
                     input int cnt, input int ex, input int lb);
    vec_t r;
    r.valid = v;
    r.din   = WIDTH'(d);
    r.lk    = lk;
    r.pl    = pl;
    r.cnt   = ERR_W'(cnt);
    r.ex    = WIDTH'(ex);
    r.lb    = WIDTH'(lb);
    vecs.push_back(r);
  endtask

  // Drive one sample, let one edge pass, return 1 time unit after it.
  task automatic apply(input logic v, input int d);
    din_valid = v;
    din       = WIDTH'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    sat_in    = '0;
    sat_inc   = 1'b0;

    // Lock on 0..3, hold through a gap, run to E, wrap through F->0.
    add(1, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 2, 0);
    add(1, 2, 0, 0, 0, 3, 0);
    add(1, 3, 1, 0, 0, 4, 0);
    add(0, 9, 1, 0, 0, 4, 0);
    for (int d = 4; d <= 13; d++) add(1, d, 1, 0, 0, d + 1, 0);
    add(1, 14, 1, 0, 0, 15, 0);
    add(1, 15, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 2, 0);
    add(1, 2, 1, 0, 0, 3, 0);
    add(1, 3, 1, 0, 0, 4, 0);
    add(1, 4, 1, 0, 0, 5, 0);
    // Break at expected=5: one-cycle pulse, count 1, last_bad 9.
    add(1, 9, 0, 1, 1, 5, 9);
    add(0, 0, 0, 0, 1, 5, 9);
`ifdef COUNT_SEQ_RELOCK_EN
    add(1, 9,  0, 0, 1, 10, 9);
    add(1, 10, 0, 0, 1, 11, 9);
    add(1, 11, 0, 0, 1, 12, 9);
    add(1, 12, 1, 0, 1, 13, 9);
`else
    add(1, 9,  0, 0, 1, 5, 9);
    add(1, 10, 0, 0, 1, 5, 9);
    add(1, 11, 0, 0, 1, 5, 9);
    add(1, 12, 0, 0, 1, 5, 9);
`endif

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].valid, int'(vecs[i].din));
      check_outs($sformatf("vec%0d", i), vecs[i].lk, vecs[i].pl, vecs[i].cnt,
                 vecs[i].ex, vecs[i].lb);
    end

    // Mismatch during acquire re-seeds silently; lock lands on A.
    do_reset();
    apply(1, 1);  check_outs("acq1", 0, 0, 0, 2, 0);
    apply(1, 2);  check_outs("acq2", 0, 0, 0, 3, 0);
    apply(1, 7);  check_outs("acq7", 0, 0, 0, 8, 0);
    apply(1, 8);  check_outs("acq8", 0, 0, 0, 9, 0);
    apply(1, 9);  check_outs("acq9", 0, 0, 0, 10, 0);
    apply(1, 10); check_outs("acqA", 1, 0, 0, 11, 0);

    // Async reset mid-acquire clears outputs without a clock edge.
    do_reset();
    apply(1, 3);
    apply(1, 4);
    check("mid.expected_before", expected, 5);
    #2 reset = 1'b1;
    #1 check_outs("mid_rst", 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    // First edge after release is treated as IDLE (run restarts at 1).
    apply(1, 9);  check_outs("post1", 0, 0, 0, 10, 0);
    apply(1, 10); check_outs("post2", 0, 0, 0, 11, 0);
    apply(1, 11); check_outs("post3", 0, 0, 0, 12, 0);
    apply(1, 12); check_outs("post4", 1, 0, 0, 13, 0);

`ifdef COUNT_SEQ_RELOCK_EN
    // 260 lock/break cycles: err_count saturates at 255.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      apply(1, 0);
      apply(1, 1);
      apply(1, 2);
      apply(1, 3);
      if (i == 259) check("sat.locked_before", locked, 1);
      apply(1, 7);
      check($sformatf("sat%0d.err_count", i), err_count, (i + 1 > 255) ? 255 : i + 1);
    end
    check("sat.err_pulse", err_pulse, 1);
    check("sat.last_bad", last_bad, 7);
`endif

    // Saturating incrementer in isolation.
    sat_in = 8'hFF; sat_inc = 1'b1; #1 check("sat_unit.ff", sat_out, 8'hFF);
    sat_in = 8'h7F; sat_inc = 1'b1; #1 check("sat_unit.7f", sat_out, 8'h80);
    sat_in = 8'h05; sat_inc = 1'b0; #1 check("sat_unit.hold", sat_out, 8'h05);
    sat_in = 8'hFE; sat_inc = 1'b1; #1 check("sat_unit.fe", sat_out, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
